elev_call_scheduler: RTL and testbench
======================================

// Module: elev_call_scheduler
// PURPOSE
//  Elevator call scheduler and motion sequencer. Latches debounced car/hall call pulses per floor and
//  runs a directional (SCAN) policy: travel floor-to-floor, open the door, then serve the next call.
//  Sits between the debounced keypad pulses and the LED/7-seg drivers; state and floor feed the display.
// PARAMETERS
//  FLOORS       2     number of floors, 2..8
//  FW           3     floor index width; must be >= clog2(FLOORS)
//  TRAVEL_TICKS 2000  tick_1k pulses to move one floor (2 s)
//  DOOR_TICKS   3000  tick_1k pulses the door stays open (3 s)
// PORTS
//  clk       in   1       50 MHz system clock
//  rst       in   1       synchronous reset, active-low
//  tick_1k   in   1       one-clk-wide 1 kHz timing strobe
//  run       in   1       start_stop level; 1 = run, 0 = pause
//  car_call  in   FLOORS  one-clk pulse per floor, in-car button
//  hall_up   in   FLOORS  one-clk pulse per floor, hall up button
//  hall_dn   in   FLOORS  one-clk pulse per floor, hall down button
//  door_hold in   1       level, door-hold button (ELEV_DOOR_HOLD_EN only)
//  floor     out  FW      current floor, 0-based
//  state     out  2       0 IDLE, 1 MOVE_UP, 2 MOVE_DN, 3 DOOR
//  dir_up    out  1       last/current travel direction, 1 = up
//  door_open out  1       1 while state==DOOR
//  call_led  out  FLOORS  OR of pending car/up/dn calls per floor
// BEHAVIOUR
//  - Reset (rst==0 at posedge): floor=0, state=IDLE, dir_up=1, all pending calls and both timers 0.
//  - Call latch: a pulse sets its pending bit on the next edge. hall_up[FLOORS-1] and hall_dn[0] are
//    ignored. A call for the current floor while IDLE sends the FSM to DOOR and is not latched.
//    A call for the current floor while in DOOR restarts the door timer and is not latched.
//  - IDLE: no pending call -> stay. Else if a call exists in the dir_up direction, move that way;
//    else move the opposite way. Transition takes one clk; travel timer starts at 0.
//  - MOVE_UP/MOVE_DN: timer counts tick_1k; on the tick that makes it TRAVEL_TICKS, floor+/-1 and the
//    timer clears in the same edge. At the new floor, stop (-> DOOR) if car_call pending, or hall call
//    pending in the travel direction, or no pending calls beyond this floor in the travel direction
//    (then a pending opposite-direction hall call also stops it). Else keep moving.
//  - Entering DOOR clears car_call and served hall bits for that floor. A new call for that floor
//    arriving on the clearing edge is dropped (treated as served).
//  - DOOR: timer counts to DOOR_TICKS, then -> IDLE; re-evaluation happens on the following clk.
//  - floor never leaves 0..FLOORS-1: at the end floor, direction logic never selects beyond it.
//  - run==0: state, floor and both timers freeze; calls keep latching; outputs hold. run 0->1 resumes
//    mid-travel with the timer unchanged.
//  - Reset mid-travel: immediate return to floor 0, IDLE, all calls cleared.
//  - All outputs are registered; call_led follows pending bits with 1-clk latency from a pulse.
// CONFIGURATION
//  ELEV_DOOR_HOLD_EN defined: while state==DOOR and door_hold==1, the door timer is held at 0; on
//    release it counts the full DOOR_TICKS. The door_hold port exists.
//  Undefined: the door_hold port is absent; the door always closes after DOOR_TICKS.
// STRUCTURE
//  elev_pkg: state encodings ST_IDLE/ST_UP/ST_DN/ST_DOOR, default tick constants, clog2 function.
//  One sub-module: elev_tick_timer (clear, enable, tick, parameter LIMIT -> done). Two instances:
//  travel and door. Call bookkeeping and direction selection stay in this module.
// TESTING (bench: FLOORS=4, TRAVEL_TICKS=4, DOOR_TICKS=3, tick every 5 clk)
//  1 reset, then car_call[2] pulse -> MOVE_UP, floor 1 after 4 ticks, floor 2 after 8, DOOR, call_led=0000
//  2 at floor 0 IDLE, hall_up[0] -> DOOR next clk, door_open=1 for 3 ticks, then IDLE, nothing latched
//  3 moving up from 0, latch hall_dn[1] and car_call[3] -> passes floor 1, stops at 3, then down to 1
//  4 run=0 for 20 clk mid-travel -> floor/state/timer frozen; car_call[1] still lights call_led[1]
//  5 hall_up[3], hall_dn[0] pulses -> ignored, call_led stays 0000, state IDLE
//  6 ELEV_DOOR_HOLD_EN: door_hold=1 for 10 ticks in DOOR -> stays DOOR; closes 3 ticks after release

Source files
------------

// File: rtl/elev_call_scheduler_pkg.sv
// Shared state encodings, default tick constants and a width helper for the elevator scheduler.
package elev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DN   = 2'd2,
    ST_DOOR = 2'd3
  } state_t;

  localparam int TRAVEL_TICKS_DEF = 2000;
  localparam int DOOR_TICKS_DEF   = 3000;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/elev_call_scheduler_if.sv
// Keypad-side calls and display-side status of elev_call_scheduler.
// door_hold exists only when ELEV_DOOR_HOLD_EN is defined.
interface elev_call_scheduler_if #(
  parameter int FLOORS = 2,
  parameter int FW     = 3
);
  logic              run;
  logic [FLOORS-1:0] car_call;
  logic [FLOORS-1:0] hall_up;
  logic [FLOORS-1:0] hall_dn;
`ifdef ELEV_DOOR_HOLD_EN
  logic              door_hold;
`endif
  logic [FW-1:0]     floor;
  logic [1:0]        state;
  logic              dir_up;
  logic              door_open;
  logic [FLOORS-1:0] call_led;

`ifdef ELEV_DOOR_HOLD_EN
  modport master (output run, car_call, hall_up, hall_dn, door_hold,
                  input  floor, state, dir_up, door_open, call_led);
  modport slave  (input  run, car_call, hall_up, hall_dn, door_hold,
                  output floor, state, dir_up, door_open, call_led);
`else
  modport master (output run, car_call, hall_up, hall_dn,
                  input  floor, state, dir_up, door_open, call_led);
  modport slave  (input  run, car_call, hall_up, hall_dn,
                  output floor, state, dir_up, door_open, call_led);
`endif
endinterface

// File: rtl/elev_call_scheduler_tick_timer.sv
// Tick counter: done fires on the tick that reaches LIMIT, and the count wraps to 0 on that same edge.
module elev_tick_timer
  import elev_pkg::*;
#(
  parameter int LIMIT = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic done
);
  localparam int W = clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign done = enable && tick && !clear && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst)               cnt <= '0;
    else if (clear)         cnt <= '0;
    else if (enable && tick) cnt <= done ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/elev_call_scheduler.sv
// SCAN elevator scheduler: latches per-floor calls, moves floor to floor, opens the door to serve.
// Optional ELEV_DOOR_HOLD_EN adds a door_hold level that keeps the door timer at zero.
module elev_call_scheduler
  import elev_pkg::*;
#(
  parameter int FLOORS       = 2,
  parameter int FW           = 3,
  parameter int TRAVEL_TICKS = TRAVEL_TICKS_DEF,
  parameter int DOOR_TICKS   = DOOR_TICKS_DEF
) (
  input logic clk,
  input logic rst,
  input logic tick_1k,
  elev_call_scheduler_if.slave bus
);
  localparam logic [FLOORS-1:0] TOP_BIT = {1'b1, {(FLOORS-1){1'b0}}};
  localparam logic [FLOORS-1:0] BOT_BIT = FLOORS'(1);

  state_t            state, state_n;
  logic [FW-1:0]     floor, floor_n;
  logic              dir_up, dir_n;
  logic [FLOORS-1:0] pc, pu, pd, pend;
  logic [FLOORS-1:0] in_car, in_up, in_dn, in_any;
  logic [FLOORS-1:0] here_oh, up_oh, dn_oh;
  logic [FLOORS-1:0] clr_c, clr_u, clr_d, drop;
  logic              above, below, past_up, past_dn;
  logic              in_here, here_pend, stop_up, stop_dn;
  logic              trv_clr, dr_clr, trv_en, dr_en, trv_done, dr_done, hold;
  int                fi;

  // The top floor has no up button and floor 0 has no down button.
  assign in_car = bus.car_call;
  assign in_up  = bus.hall_up & ~TOP_BIT;
  assign in_dn  = bus.hall_dn & ~BOT_BIT;
  assign in_any = in_car | in_up | in_dn;
  assign pend   = pc | pu | pd;
  assign fi     = int'(floor);

`ifdef ELEV_DOOR_HOLD_EN
  assign hold = bus.door_hold;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    above   = 1'b0;
    below   = 1'b0;
    past_up = 1'b0;
    past_dn = 1'b0;
    here_oh = '0;
    up_oh   = '0;
    dn_oh   = '0;
    for (int i = 0; i < FLOORS; i++) begin
      here_oh[i] = (i == fi);
      up_oh[i]   = (i == fi + 1);
      dn_oh[i]   = (i == fi - 1);
      if (i > fi)     above   = above   | pend[i];
      if (i < fi)     below   = below   | pend[i];
      if (i > fi + 1) past_up = past_up | pend[i];
      if (i < fi - 1) past_dn = past_dn | pend[i];
    end
    in_here   = |(in_any & here_oh);
    here_pend = |(pend & here_oh);
    stop_up   = |((pc | pu) & up_oh);
    stop_dn   = |((pc | pd) & dn_oh);
  end

  assign trv_en = bus.run && (state == ST_UP || state == ST_DN);
  assign dr_en  = bus.run && (state == ST_DOOR);

  elev_tick_timer #(.LIMIT(TRAVEL_TICKS)) u_travel (
    .clk(clk), .rst(rst), .clear(trv_clr), .enable(trv_en), .tick(tick_1k), .done(trv_done)
  );

  elev_tick_timer #(.LIMIT(DOOR_TICKS)) u_door (
    .clk(clk), .rst(rst), .clear(dr_clr), .enable(dr_en), .tick(tick_1k), .done(dr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      floor  <= '0;
      dir_up <= 1'b1;
      pc     <= '0;
      pu     <= '0;
      pd     <= '0;
    end else begin
      state  <= state_n;
      floor  <= floor_n;
      dir_up <= dir_n;
      pc     <= (pc & ~clr_c) | (in_car & ~drop);
      pu     <= (pu & ~clr_u) | (in_up  & ~drop);
      pd     <= (pd & ~clr_d) | (in_dn  & ~drop);
    end
  end

  // Arrival decisions look at the floor being entered (up_oh/dn_oh), not the one being left.
  always_comb begin
    state_n = state;
    floor_n = floor;
    dir_n   = dir_up;
    trv_clr = 1'b0;
    dr_clr  = 1'b0;
    clr_c   = '0;
    clr_u   = '0;
    clr_d   = '0;
    drop    = '0;
    if (bus.run) begin
      case (state)
        ST_IDLE: begin
          if (in_here) begin
            state_n = ST_DOOR;
            dr_clr  = 1'b1;
            drop    = here_oh;
          end else if (dir_up ? above : below) begin
            state_n = dir_up ? ST_UP : ST_DN;
            trv_clr = 1'b1;
          end else if (dir_up ? below : above) begin
            state_n = dir_up ? ST_DN : ST_UP;
            dir_n   = !dir_up;
            trv_clr = 1'b1;
          end else if (here_pend) begin
            state_n = ST_DOOR;
            dr_clr  = 1'b1;
            clr_c   = here_oh;
            clr_u   = here_oh;
            clr_d   = here_oh;
          end
        end
        ST_UP: begin
          if (trv_done) begin
            floor_n = floor + FW'(1);
            if (stop_up || !past_up) begin
              state_n = ST_DOOR;
              dr_clr  = 1'b1;
              drop    = up_oh;
              clr_c   = up_oh;
              clr_u   = up_oh;
              if (!past_up) clr_d = up_oh;
            end
          end
        end
        ST_DN: begin
          if (trv_done) begin
            floor_n = floor - FW'(1);
            if (stop_dn || !past_dn) begin
              state_n = ST_DOOR;
              dr_clr  = 1'b1;
              drop    = dn_oh;
              clr_c   = dn_oh;
              clr_d   = dn_oh;
              if (!past_dn) clr_u = dn_oh;
            end
          end
        end
        ST_DOOR: begin
          if (in_here) begin
            dr_clr = 1'b1;
            drop   = here_oh;
          end else if (hold) begin
            dr_clr = 1'b1;
          end else if (dr_done) begin
            state_n = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.floor     = floor;
    bus.state     = state;
    bus.dir_up    = dir_up;
    bus.door_open = (state == ST_DOOR);
    bus.call_led  = pend;
  end

endmodule

// File: tb/tb_elev_call_scheduler.sv
// Bench for elev_call_scheduler: directed vector table, corner sequences, random calls vs a reference model.
module tb_elev_call_scheduler;
  localparam int FLOORS = 4;
  localparam int FW     = 3;
  localparam int TT     = 4;
  localparam int DT     = 3;

  logic clk = 1'b0, rst = 1'b0, tick_1k = 1'b0;
  initial forever #5 clk = ~clk;

  elev_call_scheduler_if #(.FLOORS(FLOORS), .FW(FW)) bus();

  elev_call_scheduler #(.FLOORS(FLOORS), .FW(FW), .TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .tick_1k(tick_1k), .bus(bus)
  );

  int n_chk = 0, n_fail = 0, tcnt = 0;

  // Reference model: floor index, state code, direction, per-floor pending calls, tick counts.
  int m_floor, m_state, m_tt, m_dt;
  bit m_dir;
  bit m_car[FLOORS], m_up[FLOORS], m_dn[FLOORS];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit any_pend(input int lo, input int hi);
    for (int f = lo; f <= hi; f++)
      if (f >= 0 && f < FLOORS && (m_car[f] || m_up[f] || m_dn[f])) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step();
    bit ic[FLOORS], iu[FLOORS], id[FLOORS];
    bit here_in, hold, beyond, go_up, up_dir;
    int f, nf, drop_f;
    if (!rst) begin
      m_floor = 0; m_state = 0; m_dir = 1'b1; m_tt = 0; m_dt = 0;
      for (int i = 0; i < FLOORS; i++) begin m_car[i] = 0; m_up[i] = 0; m_dn[i] = 0; end
      return;
    end
    for (int i = 0; i < FLOORS; i++) begin
      ic[i] = bus.car_call[i];
      iu[i] = bus.hall_up[i] && (i != FLOORS - 1);
      id[i] = bus.hall_dn[i] && (i != 0);
    end
`ifdef ELEV_DOOR_HOLD_EN
    hold = bus.door_hold;
`else
    hold = 1'b0;
`endif
    drop_f = -1;
    f = m_floor;
    if (bus.run) begin
      here_in = ic[f] || iu[f] || id[f];
      case (m_state)
        0: begin
          if (here_in) begin
            m_state = 3; m_dt = 0; drop_f = f;
          end else if (any_pend(f + 1, FLOORS - 1) || any_pend(0, f - 1)) begin
            go_up = m_dir ? any_pend(f + 1, FLOORS - 1) : !any_pend(0, f - 1);
            m_dir = go_up; m_state = go_up ? 1 : 2; m_tt = 0;
          end else if (any_pend(f, f)) begin
            m_state = 3; m_dt = 0; m_car[f] = 0; m_up[f] = 0; m_dn[f] = 0;
          end
        end
        1, 2: begin
          if (tick_1k) begin
            m_tt++;
            if (m_tt == TT) begin
              m_tt = 0;
              up_dir = (m_state == 1);
              nf = up_dir ? f + 1 : f - 1;
              m_floor = nf;
              beyond = up_dir ? any_pend(nf + 1, FLOORS - 1) : any_pend(0, nf - 1);
              if (m_car[nf] || (up_dir ? m_up[nf] : m_dn[nf]) || !beyond) begin
                m_car[nf] = 0;
                if (up_dir || !beyond)  m_up[nf] = 0;
                if (!up_dir || !beyond) m_dn[nf] = 0;
                m_state = 3; m_dt = 0; drop_f = nf;
              end
            end
          end
        end
        default: begin
          if (here_in) begin
            m_dt = 0; drop_f = f;
          end else if (hold) begin
            m_dt = 0;
          end else if (tick_1k) begin
            m_dt++;
            if (m_dt == DT) begin m_dt = 0; m_state = 0; end
          end
        end
      endcase
    end
    for (int i = 0; i < FLOORS; i++) if (i != drop_f) begin
      m_car[i] |= ic[i]; m_up[i] |= iu[i]; m_dn[i] |= id[i];
    end
  endtask

  task automatic check_model();
    logic [FLOORS-1:0] led;
    led = '0;
    for (int i = 0; i < FLOORS; i++) led[i] = m_car[i] | m_up[i] | m_dn[i];
    chk("model_floor", int'(bus.floor), m_floor);
    chk("model_state", int'(bus.state), m_state);
    chk("model_dir_up", int'(bus.dir_up), int'(m_dir));
    chk("model_door_open", int'(bus.door_open), int'(m_state == 3));
    chk("model_call_led", int'(bus.call_led), int'(led));
  endtask

  // One clock: model and DUT both consume the inputs present at this edge.
  task automatic cycle();
    @(posedge clk); #1;
    model_step();
    check_model();
    bus.car_call = '0; bus.hall_up = '0; bus.hall_dn = '0;
    tcnt++;
    tick_1k = (tcnt % 5 == 0);
  endtask

  task automatic wait_state(input int st, input int budget, input string nm);
    int n;
    n = 0;
    while (int'(bus.state) != st && n < budget) begin cycle(); n++; end
    chk(nm, int'(bus.state), st);
  endtask

  typedef struct {
    logic [3:0] car, up, dn;
    int         cyc;
    int         exp_floor, exp_state;
    logic [3:0] exp_led;
  } vec_t;
  vec_t tbl[14];

  initial begin
    bus.run = 1'b1; bus.car_call = '0; bus.hall_up = '0; bus.hall_dn = '0;
`ifdef ELEV_DOOR_HOLD_EN
    bus.door_hold = 1'b0;
`endif
    rst = 1'b0;
    cycle(); cycle();
    chk("reset_floor", int'(bus.floor), 0);
    chk("reset_state", int'(bus.state), 0);
    chk("reset_dir_up", int'(bus.dir_up), 1);
    chk("reset_call_led", int'(bus.call_led), 0);
    rst = 1'b1;

    //           car      up       dn      cyc fl st led
    tbl[0]  = '{4'b0100, 4'b0000, 4'b0000, 1,  0, 0, 4'b0100};
    tbl[1]  = '{4'b0000, 4'b0000, 4'b0000, 1,  0, 1, 4'b0100};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 25, 1, 1, 4'b0100};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 15, 2, 3, 4'b0000};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 15, 2, 0, 4'b0000};
    tbl[5]  = '{4'b0000, 4'b0100, 4'b0000, 1,  2, 3, 4'b0000};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 10, 2, 3, 4'b0000};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 5,  2, 0, 4'b0000};
    tbl[8]  = '{4'b0000, 4'b1000, 4'b0001, 2,  2, 0, 4'b0000};
    tbl[9]  = '{4'b0001, 4'b0000, 4'b0000, 2,  2, 2, 4'b0001};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0000, 40, 0, 3, 4'b0000};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 15, 0, 0, 4'b0000};
    tbl[12] = '{4'b0000, 4'b0001, 4'b0000, 1,  0, 3, 4'b0000};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 15, 0, 0, 4'b0000};
    for (int k = 0; k < 14; k++) begin
      bus.car_call = tbl[k].car; bus.hall_up = tbl[k].up; bus.hall_dn = tbl[k].dn;
      for (int c = 0; c < tbl[k].cyc; c++) cycle();
      chk($sformatf("vec%0d_floor", k), int'(bus.floor), tbl[k].exp_floor);
      chk($sformatf("vec%0d_state", k), int'(bus.state), tbl[k].exp_state);
      chk($sformatf("vec%0d_call_led", k), int'(bus.call_led), int'(tbl[k].exp_led));
    end

    // Pass a down call on the way up, stop at the top call, then come back for it.
    bus.car_call = 4'b1000; cycle(); cycle();
    bus.hall_dn = 4'b0010; cycle();
    wait_state(3, 100, "scan_reach_top");
    chk("scan_top_floor", int'(bus.floor), 3);
    chk("scan_top_led", int'(bus.call_led), 4'b0010);
    wait_state(0, 30, "scan_top_close");
    wait_state(3, 100, "scan_back_down");
    chk("scan_back_floor", int'(bus.floor), 1);
    chk("scan_back_dir", int'(bus.dir_up), 0);
    chk("scan_back_led", int'(bus.call_led), 0);
    wait_state(0, 30, "scan_back_close");

    // Pause mid-travel: position frozen, calls still latch.
    bus.car_call = 4'b1000; cycle(); cycle();
    for (int c = 0; c < 7; c++) cycle();
    bus.run = 1'b0; bus.car_call = 4'b0010;
    for (int c = 0; c < 20; c++) cycle();
    chk("pause_floor", int'(bus.floor), 1);
    chk("pause_state", int'(bus.state), 1);
    chk("pause_call_led", int'(bus.call_led), 4'b1010);
    bus.run = 1'b1;
    wait_state(3, 100, "resume_reach_top");
    chk("resume_top_floor", int'(bus.floor), 3);
    wait_state(0, 30, "resume_top_close");
    wait_state(3, 100, "resume_back_down");
    chk("resume_back_floor", int'(bus.floor), 1);
    wait_state(0, 30, "resume_back_close");

    // Reset while travelling.
    bus.car_call = 4'b1000; cycle(); cycle();
    for (int c = 0; c < 25; c++) cycle();
    chk("midtravel_floor", int'(bus.floor), 2);
    rst = 1'b0; cycle(); rst = 1'b1;
    chk("midreset_floor", int'(bus.floor), 0);
    chk("midreset_state", int'(bus.state), 0);
    chk("midreset_dir_up", int'(bus.dir_up), 1);
    chk("midreset_call_led", int'(bus.call_led), 0);

`ifdef ELEV_DOOR_HOLD_EN
    bus.car_call = 4'b0001; cycle();
    chk("hold_open", int'(bus.state), 3);
    bus.door_hold = 1'b1;
    for (int c = 0; c < 50; c++) cycle();
    chk("hold_still_open", int'(bus.state), 3);
    bus.door_hold = 1'b0;
    for (int c = 0; c < 10; c++) cycle();
    chk("hold_release_open", int'(bus.state), 3);
    for (int c = 0; c < 5; c++) cycle();
    chk("hold_release_closed", int'(bus.state), 0);
`endif

    // Random calls, pauses and occasional resets against the model.
    for (int n = 0; n < 3000; n++) begin
      bus.car_call = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      bus.hall_up  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      bus.hall_dn  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      if (bus.run ? ($urandom_range(0, 60) == 0) : ($urandom_range(0, 7) == 0)) bus.run = !bus.run;
      rst = ($urandom_range(0, 700) != 0);
`ifdef ELEV_DOOR_HOLD_EN
      if ($urandom_range(0, 30) == 0) bus.door_hold = !bus.door_hold;
`endif
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
